// File: rtl/bram_pacer.sv
// Programmable multi-tap pacing counter for BRAM reads on the SPI frame path.
// Latency: outputs registered, pulses one cycle after the count match; stall holds count and suppresses pulses.
module bram_pacer #(
    parameter int CNT_W          = 11,
    parameter int BURST_W        = 16,
    parameter int NUM_TAPS       = 2,
    parameter int DEFAULT_PERIOD = 12,
    parameter logic [NUM_TAPS*CNT_W-1:0] TAP_OFFSETS = {11'd11, 11'd9}
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [CNT_W-1:0]    period_in,
    input  logic                period_valid_in,
    input  logic                mode_in,
    input  logic [BURST_W-1:0]  burst_len_in,
    input  logic                start_in,
    input  logic                stop_in,
    input  logic                stall_in,
    output logic                busy_out,
    output logic [CNT_W-1:0]    count_out,
    output logic                wrap_out,
    output logic [NUM_TAPS-1:0] tap_out,
    output logic                done_out,
    output logic                period_err_out
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     r_pend_period;
    logic                 r_pend_vld;
    logic                 r_mode;
    logic [BURST_W-1:0]   r_burst_len;
    logic [BURST_W-1:0]   r_burst_cnt;
    logic                 r_wrap;
    logic [NUM_TAPS-1:0]  r_tap;
    logic                 r_done;
    logic                 r_err;

    logic                 w_load_bad;
    logic                 w_load_ok;
    logic                 w_at_end;
    logic [BURST_W-1:0]   w_burst_nxt;
    logic                 w_burst_end;
    logic [NUM_TAPS-1:0]  w_tap_hit;

    assign w_load_bad  = period_valid_in && (period_in < CNT_W'(2));
    assign w_load_ok   = period_valid_in && !w_load_bad;
    assign w_at_end    = (r_count == (r_period - CNT_W'(1)));
    assign w_burst_nxt = r_burst_cnt + BURST_W'(1);
    assign w_burst_end = r_mode && (w_burst_nxt == r_burst_len);

    always_comb begin
        w_tap_hit = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_tap_hit[k] = (r_count == TAP_OFFSETS[k*CNT_W +: CNT_W]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_period      <= CNT_W'(DEFAULT_PERIOD);
            r_pend_period <= '0;
            r_pend_vld    <= 1'b0;
            r_mode        <= 1'b0;
            r_burst_len   <= '0;
            r_burst_cnt   <= '0;
            r_wrap        <= 1'b0;
            r_tap         <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_tap  <= '0;
            r_done <= 1'b0;
            r_err  <= w_load_bad;
            case (r_state)
                ST_IDLE: begin
                    // A pending value left over from a burst that ended on its wrap is applied here.
                    if (w_load_ok) begin
                        r_period <= period_in;
                    end else if (r_pend_vld) begin
                        r_period <= r_pend_period;
                    end
                    r_pend_vld <= 1'b0;
                    if (start_in && !stop_in) begin
                        r_state     <= ST_RUN;
                        r_count     <= '0;
                        r_mode      <= mode_in;
                        r_burst_len <= (burst_len_in == '0) ? BURST_W'(1) : burst_len_in;
                        r_burst_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop_in) begin
                        r_state     <= ST_IDLE;
                        r_count     <= '0;
                        r_burst_cnt <= '0;
                    end else if (!stall_in) begin
                        r_tap  <= w_tap_hit;
                        r_wrap <= w_at_end;
                        if (w_at_end) begin
                            r_count <= '0;
                            if (r_pend_vld) begin
                                r_period   <= r_pend_period;
                                r_pend_vld <= 1'b0;
                            end
                            if (r_mode) begin
                                r_burst_cnt <= w_burst_nxt;
                                if (w_burst_end) begin
                                    r_done      <= 1'b1;
                                    r_state     <= ST_IDLE;
                                    r_burst_cnt <= '0;
                                end
                            end
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    // Placed last so a load on a wrap edge stays pending for the following period.
                    if (w_load_ok) begin
                        r_pend_period <= period_in;
                        r_pend_vld    <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out       = (r_state == ST_RUN);
    assign count_out      = r_count;
    assign wrap_out       = r_wrap;
    assign tap_out        = r_tap;
    assign done_out       = r_done;
    assign period_err_out = r_err;

endmodule

// File: doc/bram_pacer.md
# bram_pacer

Programmable, multi-tap pacing counter that schedules BRAM read requests and line/block boundaries for the SPI frame-transfer path. It is the generalised successor to the fixed-period BRAM counter: period, counter width and tap count are parametrised, and the period is runtime-loadable. It adds stall, start/stop control and a one-shot burst mode that runs a fixed number of periods and then signals completion. It sits between the SPI transmit controller and the frame-buffer BRAM read port.

## Interface
Parameters:
- CNT_W, 11, width of count and period.
- BURST_W, 16, width of burst length and burst counter.
- NUM_TAPS, 2, number of independent tap pulse outputs.
- DEFAULT_PERIOD, 12, period after reset; must be in range 2..2^CNT_W-1.
- TAP_OFFSETS, {11'd11, 11'd9}, packed NUM_TAPS*CNT_W vector; slice k, bits [k*CNT_W +: CNT_W], is the offset of tap k.

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- period_in  in  CNT_W  new period value.
- period_valid_in  in  1  request to load period_in.
- mode_in  in  1  run mode: 0 = free-run, 1 = one-shot burst; sampled on an accepted start.
- burst_len_in  in  BURST_W  number of periods per burst; sampled on an accepted start.
- start_in  in  1  start request.
- stop_in  in  1  abort request.
- stall_in  in  1  hold the count.
- busy_out  out  1  state is RUN.
- count_out  out  CNT_W  current count.
- wrap_out  out  1  one-cycle pulse on each period wrap.
- tap_out  out  NUM_TAPS  one-cycle pulse per tap.
- done_out  out  1  one-cycle pulse at the end of a burst.
- period_err_out  out  1  one-cycle pulse when a period load is rejected.

## Operation
- States are IDLE and RUN. All outputs are registered.
- Reset (asynchronous assert, synchronous release) sets state=IDLE, count=0, period=DEFAULT_PERIOD, burst counter=0, and every output to 0.
- IDLE -> RUN on start_in when stop_in=0. On that edge:
  - count is set to 0.
  - mode_in is latched.
  - burst_len_in is latched; a value of 0 is treated as 1.
  - The burst counter is cleared.
- start_in while in RUN is ignored.
- In RUN, on an edge with stall_in=0 (an advancing edge):
  - count <= (count==period-1) ? 0 : count+1.
  - wrap_out <= (count==period-1).
  - tap_out[k] <= (count==TAP_OFFSETS[k]).
- In RUN, on an edge with stall_in=1: count holds, and wrap_out and tap_out are 0 on the next cycle.
- A tap whose offset is ≥ period never fires. Multiple taps with equal offsets fire together.
- In burst mode, each wrap increments the burst counter. On the wrap that makes the counter equal the latched burst length:
  - wrap_out and done_out pulse together.
  - state -> IDLE and count -> 0 on the same edge.
- Free-run mode never asserts done_out.
- stop_in in RUN forces IDLE and count=0 on the next edge. No done_out is produced; tap and wrap pulses that would have been registered on that edge are suppressed.
- start_in and stop_in together: stop wins; state is or stays IDLE.
- Period load with period_valid_in=1:
  - period_in < 2 is rejected: period_err_out pulses and the old period is kept.
  - In IDLE, the new period takes effect immediately.
  - In RUN, the value is held pending and takes effect on the next advancing wrap edge. A later request overwrites the pending value.
  - A load coinciding with a wrap edge applies from the following period, not the one that just started.
- Width rules: comparisons are unsigned CNT_W; the burst counter is BURST_W and does not overflow, because it is cleared on termination.

## Timing
- Start accepted at edge t: busy_out=1 and count_out=0 during cycle t+1; first advance at edge t+1.
- Tap latency: tap_out[k] is high in the cycle after count_out==offset, i.e. while count_out==offset+1 (or 0 if offset==period-1). This matches the legacy read_request/hit_max alignment for default parameters.
- wrap_out is high while count_out==0 following a wrap.
- Burst of L periods of length P with no stall: done_out is high exactly L*P cycles after busy_out rises, and busy_out is 0 in the same cycle.
- Stall of S cycles delays every subsequent pulse by exactly S cycles.
- Reset asserted mid-operation clears outputs asynchronously within the same cycle.

## Test plan
- Reset, start free-run with defaults and no stall -> tap_out[0] pulses when count_out==10, tap_out[1] and wrap_out pulse when count_out==0, repeating every 12 cycles; done_out stays 0.
- Burst mode, period_in=5 loaded in IDLE, burst_len_in=3 -> exactly 3 wrap pulses; done_out coincides with the third wrap, 15 cycles after busy_out rises; then busy_out=0 and count_out=0.
- Stall held 4 cycles at count 7 -> count_out holds at 7, no tap/wrap pulses during the stall, and the next tap_out[0] arrives 4 cycles late.
- period_in=8 loaded at count 3 during RUN -> current period completes at 12; next wrap interval is 8; tap_out[1] (offset 11) stops firing. period_in=1 -> period_err_out pulses once and the period is unchanged.
- start_in and stop_in asserted together in IDLE -> stays IDLE. stop_in mid-burst at count 6 -> IDLE next cycle with no done_out and no pulses.
- rst_n_in low mid-burst -> all outputs 0 immediately; after release, period is 12 and state is IDLE.
